// File: rtl/fd_corner_collector_pkg.sv
// Shared widths and FSM encoding for the FAST9 corner collector.
package fd_corner_collector_pkg;
  localparam int FD_ADDR_W = 15;
  localparam int FD_PIX_W  = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fd_state_e;
endpackage

// File: rtl/fd_corner_collector_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is legal when a pop
// happens in the same cycle.
module fd_sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra pointer MSB tells a full ring apart from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fd_corner_collector.sv
// Collects deduplicated FAST9 corner reports into a FIFO, streams them out and
// reports per-frame corner/drop counts once the frame has drained.
module fd_corner_collector
  import fd_corner_collector_pkg::*;
#(
  parameter int ADDR_W = FD_ADDR_W,
  parameter int PIX_W  = FD_PIX_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              isCorner,
  input  logic [ADDR_W-1:0] refAddr,
  input  logic [PIX_W-1:0]  refPixel,
  input  logic              frameEnd,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [PIX_W-1:0]  outPixel,
  output logic              frameDone,
  output logic [CNT_W-1:0]  frameCorners,
  output logic [CNT_W-1:0]  frameDrops,
  output logic              overflow
);
  localparam int W = ADDR_W + PIX_W;

  fd_state_e         state;
  logic              last_valid;
  logic [ADDR_W-1:0] last_addr;
  logic [CNT_W-1:0]  corner_cnt, drop_cnt;
  logic              full, empty, pop, push, is_new, drop;
  logic [W-1:0]      head;

  assign pop      = !empty && outReady;
  assign is_new   = (state == ST_RUN) && isCorner && (!last_valid || refAddr != last_addr);
  assign push     = is_new && (!full || pop);
  assign drop     = is_new && full && !pop;
  assign outValid = !empty;
  // Storage is not reset, so mask the head while nothing is queued.
  assign {outAddr, outPixel} = empty ? '0 : head;

  fd_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .nReset(nReset),
    .push  (push),
    .wdata ({refAddr, refPixel}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_RUN;
      last_valid   <= 1'b0;
      last_addr    <= '0;
      corner_cnt   <= '0;
      drop_cnt     <= '0;
      frameDone    <= 1'b0;
      frameCorners <= '0;
      frameDrops   <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          last_valid <= isCorner;
          if (isCorner) last_addr <= refAddr;
          if (push && !(&corner_cnt)) corner_cnt <= corner_cnt + CNT_W'(1);
          if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
          end
          if (frameEnd) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Frame results are published on the same edge frameDone rises.
          if (empty) begin
            state        <= ST_DONE;
            frameDone    <= 1'b1;
            frameCorners <= corner_cnt;
            frameDrops   <= drop_cnt;
            corner_cnt   <= '0;
            drop_cnt     <= '0;
            overflow     <= 1'b0;
            last_valid   <= 1'b0;
          end
        end
        ST_DONE: begin
          frameDone <= 1'b0;
          state     <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fd_corner_collector.sv
// Scenario bench for fd_corner_collector with a queue-based reference model.
module tb_fd_corner_collector;
  localparam int AW = 15;
  localparam int PW = 8;
  localparam int W  = AW + PW;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic          isCorner = 1'b0;
  logic [AW-1:0] refAddr = '0;
  logic [PW-1:0] refPixel = '0;
  logic          frameEnd = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid, frameDone, overflow;
  logic [AW-1:0] outAddr;
  logic [PW-1:0] outPixel;
  logic [15:0]   frameCorners, frameDrops;

  int checks = 0;
  int failures = 0;

  fd_corner_collector dut (
    .clock(clock), .nReset(nReset), .isCorner(isCorner), .refAddr(refAddr),
    .refPixel(refPixel), .frameEnd(frameEnd), .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .outPixel(outPixel), .frameDone(frameDone),
    .frameCorners(frameCorners), .frameDrops(frameDrops), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Reference model: the buffer is a plain queue, the frame is "intake",
  // "draining" or "just finished".
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_beats[$];
  logic [W-1:0] got[$];
  bit           m_lv = 0, m_drain = 0, m_done = 0, m_ovf = 0;
  logic [AW-1:0] m_la = '0;
  int           m_corners = 0, m_drops = 0, m_fc = 0, m_fd = 0;
  bit           m_pop, m_push;

  always @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      mq.delete();
      m_lv = 0; m_drain = 0; m_done = 0; m_ovf = 0;
      m_corners = 0; m_drops = 0; m_fc = 0; m_fd = 0;
    end else begin
      m_pop  = (mq.size() != 0) && outReady;
      m_push = 0;
      if (m_done) m_done = 0;
      else if (m_drain) begin
        if (mq.size() == 0) begin
          m_drain = 0; m_done = 1;
          m_fc = m_corners; m_fd = m_drops;
          m_corners = 0; m_drops = 0; m_ovf = 0; m_lv = 0;
        end
      end else begin
        if (isCorner && (!m_lv || refAddr != m_la)) begin
          if (mq.size() < DEPTH || m_pop) begin
            m_push = 1;
            if (m_corners < 65535) m_corners++;
          end else begin
            if (m_drops < 65535) m_drops++;
            m_ovf = 1;
          end
        end
        m_lv = isCorner;
        if (isCorner) m_la = refAddr;
        if (frameEnd) m_drain = 1;
      end
      if (m_pop) exp_beats.push_back(mq.pop_front());
      if (m_push) mq.push_back({refAddr, refPixel});
    end
  end

  always @(negedge clock)
    if (nReset && outValid && outReady) got.push_back({outAddr, outPixel});

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic rep(input logic [AW-1:0] a, input logic [PW-1:0] p);
    isCorner = 1'b1; refAddr = a; refPixel = p; cyc();
  endtask

  task automatic idle(input int n);
    isCorner = 1'b0; frameEnd = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic pulse_end();
    frameEnd = 1'b1; cyc(); frameEnd = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (frameDone) begin ok = 1; break; end
      cyc();
    end
  endtask

  task automatic clear_beats();
    got.delete(); exp_beats.delete();
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (2) cyc();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    checks++; if ({outAddr, outPixel} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {outAddr, outPixel}); end
    checks++; if ({frameDone, overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {frameDone, overflow}); end
    checks++; if ({frameCorners, frameDrops} !== '0) begin failures++; $display("FAIL reset_counts got=%h exp=0", {frameCorners, frameDrops}); end
    nReset = 1'b1;
    cyc();
  endtask

  task automatic test_hold_dedup();
    bit ok;
    clear_beats();
    outReady = 1'b1;
    repeat (3) rep(15'd100, 8'h5A);
    idle(3);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL hold_beats got=%0d exp=1", got.size()); end
    checks++; if (got.size() > 0 && got[0] !== {15'd100, 8'h5A}) begin failures++; $display("FAIL hold_value got=%h exp=%h", got[0], {15'd100, 8'h5A}); end
    pulse_end();
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_done got=timeout exp=frameDone"); end
    checks++; if (frameCorners !== 16'd1 || frameDrops !== 16'd0) begin failures++; $display("FAIL hold_counts got=%0d/%0d exp=1/0", frameCorners, frameDrops); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [AW-1:0] want[3] = '{15'd7, 15'd8, 15'd8};
    clear_beats();
    outReady = 1'b1;
    rep(15'd7, 8'h11);
    rep(15'd8, 8'h22);
    idle(1);
    rep(15'd8, 8'h33);
    idle(3);
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL b2b_beats got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i][W-1:PW] !== want[i]) begin failures++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, got[i][W-1:PW], want[i]); end
    end
    pulse_end();
    wait_done(ok);
    checks++; if (!ok || frameCorners !== 16'd3) begin failures++; $display("FAIL b2b_corners got=%0d ok=%0d exp=3", frameCorners, ok); end
    idle(1);
  endtask

  task automatic test_overflow();
    bit ok;
    clear_beats();
    outReady = 1'b0;
    for (int i = 0; i < 20; i++) rep(AW'(i), PW'($urandom));
    idle(1);
    checks++; if (outValid !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_flags got=%b%b exp=11", outValid, overflow); end
    outReady = 1'b1;
    pulse_end();
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_done got=timeout exp=frameDone"); end
    checks++; if (frameCorners !== 16'd16 || frameDrops !== 16'd4) begin failures++; $display("FAIL ovf_counts got=%0d/%0d exp=16/4", frameCorners, frameDrops); end
    checks++; if (got.size() !== 16) begin failures++; $display("FAIL ovf_beats got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_beats[i] || got[i][W-1:PW] !== AW'(i)) begin failures++; $display("FAIL ovf_beat[%0d] got=%h exp=%h", i, got[i], exp_beats[i]); end
    end
    idle(1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    clear_beats();
    outReady = 1'b0;
    for (int i = 0; i < 16; i++) rep(AW'(i + 40), PW'(i));
    outReady = 1'b1;
    rep(15'd500, 8'hC3);
    idle(20);
    pulse_end();
    wait_done(ok);
    checks++; if (!ok || frameDrops !== 16'd0 || frameCorners !== 16'd17) begin failures++; $display("FAIL fpp_counts got=%0d/%0d exp=17/0", frameCorners, frameDrops); end
    checks++; if (got.size() !== 17) begin failures++; $display("FAIL fpp_beats got=%0d exp=17", got.size()); end
    checks++; if (got.size() > 0 && got[got.size()-1] !== {15'd500, 8'hC3}) begin failures++; $display("FAIL fpp_last got=%h exp=%h", got[got.size()-1], {15'd500, 8'hC3}); end
    idle(1);
  endtask

  task automatic test_drain();
    bit ok, seen;
    int pulses;
    clear_beats();
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) rep(AW'(200 + i), PW'($urandom));
    isCorner = 1'b0;
    pulse_end();
    pulses = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      outReady = i[0];
      isCorner = !seen && ($urandom_range(0, 1) == 1);
      refAddr  = AW'($urandom_range(300, 400));
      frameEnd = !seen && ($urandom_range(0, 3) == 0);
      cyc();
      if (frameDone) begin
        pulses++; seen = 1;
        checks++; if (frameCorners !== 16'd5 || frameDrops !== 16'd0) begin failures++; $display("FAIL drain_counts got=%0d/%0d exp=5/0", frameCorners, frameDrops); end
      end
    end
    frameEnd = 1'b0; isCorner = 1'b0;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL drain_pulses got=%0d exp=1", pulses); end
    checks++; if (got.size() !== 5) begin failures++; $display("FAIL drain_beats got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i][W-1:PW] !== AW'(200 + i) || got[i] !== exp_beats[i]) begin failures++; $display("FAIL drain_beat[%0d] got=%h exp=%h", i, got[i], exp_beats[i]); end
    end
    outReady = 1'b1;
    rep(15'd42, 8'h01);
    idle(2);
    pulse_end();
    wait_done(ok);
    checks++; if (!ok || frameCorners !== 16'd1 || frameDrops !== 16'd0) begin failures++; $display("FAIL drain_next got=%0d/%0d exp=1/0", frameCorners, frameDrops); end
    idle(1);
  endtask

  task automatic test_async_reset();
    bit ok;
    int pulses;
    clear_beats();
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) rep(AW'(600 + i), 8'h77);
    isCorner = 1'b0;
    pulse_end();
    cyc();
    #2 nReset = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_flags got=%b%b exp=00", outValid, overflow); end
    checks++; if (frameCorners !== 16'd0 || frameDrops !== 16'd0) begin failures++; $display("FAIL arst_counts got=%0d/%0d exp=0/0", frameCorners, frameDrops); end
    pulses = 0;
    repeat (2) begin cyc(); if (frameDone) pulses++; end
    nReset = 1'b1;
    outReady = 1'b1;
    repeat (4) begin cyc(); if (frameDone) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL arst_nodone got=%0d exp=0", pulses); end
    rep(15'd777, 8'h9C);
    idle(3);
    checks++; if (got.size() !== 1 || got[0] !== {15'd777, 8'h9C}) begin failures++; $display("FAIL arst_after got=%0d beats exp=1 of %h", got.size(), {15'd777, 8'h9C}); end
    pulse_end();
    wait_done(ok);
    checks++; if (!ok || frameCorners !== 16'd1) begin failures++; $display("FAIL arst_corners got=%0d exp=1", frameCorners); end
    idle(1);
  endtask

  task automatic test_random();
    bit ok;
    clear_beats();
    for (int i = 0; i < 600; i++) begin
      isCorner = ($urandom_range(0, 2) != 0);
      refAddr  = AW'($urandom_range(0, 5));
      refPixel = PW'($urandom);
      outReady = ($urandom_range(0, 9) < 4);
      frameEnd = ($urandom_range(0, 59) == 0);
      cyc();
      checks++; if (outValid !== (mq.size() != 0) || overflow !== m_ovf || frameDone !== m_done) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got=%b%b%b exp=%b%b%b", i, outValid, overflow, frameDone, mq.size() != 0, m_ovf, m_done);
      end
      if (mq.size() != 0) begin
        checks++; if ({outAddr, outPixel} !== mq[0]) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, {outAddr, outPixel}, mq[0]); end
      end
      if (m_done) begin
        checks++; if (frameCorners !== 16'(m_fc) || frameDrops !== 16'(m_fd)) begin failures++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, frameCorners, frameDrops, m_fc, m_fd); end
      end
    end
    isCorner = 1'b0; outReady = 1'b1;
    idle(3);
    pulse_end();
    wait_done(ok);
    checks++; if (!ok || frameCorners !== 16'(m_fc) || frameDrops !== 16'(m_fd)) begin failures++; $display("FAIL rnd_final got=%0d/%0d exp=%0d/%0d", frameCorners, frameDrops, m_fc, m_fd); end
    idle(2);
    checks++; if (got.size() !== exp_beats.size()) begin failures++; $display("FAIL rnd_beats got=%0d exp=%0d", got.size(), exp_beats.size()); end
    for (int i = 0; i < got.size() && i < exp_beats.size(); i++) begin
      if (got[i] !== exp_beats[i]) begin
        checks++; failures++; $display("FAIL rnd_beat[%0d] got=%h exp=%h", i, got[i], exp_beats[i]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_dedup();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
